// File: rtl/write_controller.sv
// Register-write endpoint: collects an address byte plus DATA_LENGTH data bytes from the
// RX packet stream, pulses a 32-bit register write, then returns a one-byte acknowledge.

typedef struct packed {
    logic [7:0] Source;
    logic [7:0] Destination;
    logic [7:0] Length;
    logic       SoP;
    logic       EoP;
    logic [7:0] Data;
    logic       Valid;
} uart_packet;

module write_controller #(
    parameter logic [7:0] WRITE_DEST  = 8'h01,
    parameter int         DATA_LENGTH = 4
) (
    input  logic        ipClk,
    input  logic        ipReset,
    input  uart_packet  ipRxStream,
    input  logic        ipTxReady,
    output uart_packet  opTxStream,
    output logic [7:0]  opWrAddress,
    output logic [31:0] opWrData,
    output logic        opWrEnable,
    output logic        opBusy
);

    typedef enum logic [2:0] {
        IDLE,
        RX_DATA,
        DISCARD,
        WRITE,
        ACK
    } state_t;

    localparam logic [3:0] LAST_COUNT = 4'(DATA_LENGTH);

    state_t      state_reg;
    logic [3:0]  count_reg;
    logic [23:0] shift_reg;
    logic [7:0]  addr_reg;
    logic [7:0]  reply_reg;

    logic start_hit;
    logic unused_length;

    // A start byte for this block; in RX_DATA it also restarts the packet.
    assign start_hit = ipRxStream.Valid && ipRxStream.SoP &&
                       (ipRxStream.Destination == WRITE_DEST);

    assign opBusy        = (state_reg != IDLE);
    assign unused_length = &{1'b0, ipRxStream.Length};

    always_ff @(posedge ipClk) begin
        if (!ipReset) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            shift_reg   <= '0;
            addr_reg    <= '0;
            reply_reg   <= '0;
            opWrEnable  <= 1'b0;
            opWrAddress <= '0;
            opWrData    <= '0;
            opTxStream  <= '0;
        end else begin
            opWrEnable <= 1'b0;
            case (state_reg)
                IDLE, RX_DATA: begin
                    if (start_hit) begin
                        addr_reg  <= ipRxStream.Data;
                        reply_reg <= ipRxStream.Source;
                        count_reg <= 4'd1;
                        shift_reg <= '0;
                        state_reg <= ipRxStream.EoP ? IDLE : RX_DATA;
                    end else if (state_reg == RX_DATA && ipRxStream.Valid) begin
                        if (ipRxStream.SoP) begin
                            state_reg <= IDLE;
                        end else begin
                            shift_reg <= {shift_reg[15:0], ipRxStream.Data};
                            count_reg <= count_reg + 4'd1;
                            if (ipRxStream.EoP) begin
                                if (count_reg == LAST_COUNT) begin
                                    state_reg   <= WRITE;
                                    opWrEnable  <= 1'b1;
                                    opWrAddress <= addr_reg;
                                    opWrData    <= {shift_reg, ipRxStream.Data};
                                end else begin
                                    state_reg <= IDLE;
                                end
                            end else if (count_reg == LAST_COUNT) begin
                                state_reg <= DISCARD;
                            end
                        end
                    end
                end
                DISCARD: begin
                    if (ipRxStream.Valid && ipRxStream.EoP) begin
                        state_reg <= IDLE;
                    end
                end
                WRITE: begin
                    state_reg              <= ACK;
                    opTxStream.Valid       <= 1'b1;
                    opTxStream.SoP         <= 1'b1;
                    opTxStream.EoP         <= 1'b1;
                    opTxStream.Length      <= 8'd1;
                    opTxStream.Data        <= addr_reg;
                    opTxStream.Source      <= WRITE_DEST;
                    opTxStream.Destination <= reply_reg;
                end
                ACK: begin
                    if (ipTxReady) begin
                        opTxStream <= '0;
                        state_reg  <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/write_controller.md
Name: write_controller

Overview:
- Register-write endpoint of the UART packet register interface; counterpart to the read path.
- Consumes a UART_PACKET stream addressed to WRITE_DEST carrying one address byte and DATA_LENGTH data bytes (MSB first).
- Issues a single-cycle 32-bit register write, then returns a 1-byte acknowledge packet to the sender on the TX packet stream.
- Sits between the UART packetiser (RX side) and the register file write port; its TX output feeds the TX packet arbiter.

Parameters:
- WRITE_DEST, 8'h01, Destination value this block accepts.
- DATA_LENGTH, 4, data bytes per write packet; payload length is DATA_LENGTH+1.

Ports:
- ipClk  input  1  system clock; all logic on the rising edge.
- ipReset  input  1  synchronous, active-low reset (0 = reset).
- ipRxStream  input  UART_PACKET  incoming packet bytes; fields Source[7:0], Destination[7:0], Length[7:0], SoP, EoP, Data[7:0], Valid. No backpressure.
- ipTxReady  input  1  downstream accepts the current opTxStream byte this cycle.
- opTxStream  output  UART_PACKET  acknowledge packet out.
- opWrAddress  output  8  register address.
- opWrData  output  32  register write data.
- opWrEnable  output  1  one-cycle write strobe.
- opBusy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset, sampled when ipReset==0 on a rising edge:
  - state=IDLE, byte counter=0.
  - opWrEnable=0, opWrAddress=0, opWrData=0.
  - All opTxStream fields 0.
  - Reset overrides every state, including mid-packet and mid-ACK; a partial packet is lost and no write occurs.
- A byte is "accepted" on a clock where ipRxStream.Valid==1 and the state allows reception.
- States:
  - IDLE:
    - A byte with SoP=1, Valid=1, Destination==WRITE_DEST latches the byte as the address, latches Source as the reply address, sets counter=1, then goes to RX_DATA.
    - If that byte also has EoP=1, go to IDLE instead (short packet, discarded).
    - Bytes for other destinations, or without SoP, are ignored.
  - RX_DATA:
    - Each accepted byte shifts into the data shift register, MSB first: data = {data[23:0], Data}. Counter increments.
    - SoP=1 mid-packet: restart. Treat the byte as a new first byte, applying the IDLE rules to it.
    - EoP=1 with counter==DATA_LENGTH (this byte being the last data byte): go to WRITE.
    - EoP=1 with any other count (short packet): discard and go to IDLE.
    - Counter reaching DATA_LENGTH+1 without EoP (long packet): go to DISCARD.
  - DISCARD: ignore bytes until an accepted byte with EoP=1, then go to IDLE. No write, no ACK.
  - WRITE:
    - Exactly one cycle: opWrEnable=1, opWrAddress=latched address, opWrData=assembled word.
    - Next state ACK.
  - ACK:
    - Drive opTxStream: Valid=1, SoP=1, EoP=1, Length=1, Data=latched address, Source=WRITE_DEST, Destination=latched reply source.
    - Hold all of these stable until a cycle with ipTxReady==1.
    - On that cycle the byte transfers; the next cycle has Valid=0, SoP=0, EoP=0, and state is IDLE.
    - ipTxReady already high on ACK entry gives a single-cycle Valid.
- opWrEnable is 0 in every state except WRITE. opWrAddress and opWrData hold their last written values.
- Latency: EoP byte accepted at edge N gives opWrEnable=1 during cycle N+1 and opTxStream.Valid=1 from cycle N+2.
- RX bytes arriving in WRITE or ACK are dropped, with no recovery of that packet; opBusy lets the upstream arbiter avoid this.
- Counter width is 4 bits minimum. DATA_LENGTH must be 1..14.

Test Plan:
- Nominal write:
  - Stimulus: SoP packet Dest=01, Src=7A, bytes 10,DE,AD,BE,EF with EoP on EF, ipTxReady=1.
  - Required: one-cycle opWrEnable with Addr=10, Data=DEADBEEF one cycle after EF; then ACK Valid/SoP/EoP, Data=10, Dest=7A, Src=01 for exactly one cycle; state back to IDLE.
- Ready backpressure:
  - Stimulus: as nominal, but ipTxReady=0 for 5 cycles after ACK starts.
  - Required: opTxStream fields held constant for 5 cycles, transfer on the first ready cycle, no second opWrEnable.
- Foreign and short packets:
  - Stimulus: Dest=02 packet 10,11,22,33,44; then Dest=01 packet 10,11,22 with EoP on 22.
  - Required: opWrEnable never asserts, opTxStream.Valid stays 0, opBusy returns to 0 after the EoP byte.
- Long packet:
  - Stimulus: Dest=01 bytes 20,01,02,03,04,05 with EoP on 05; then a valid packet 21,AA,BB,CC,DD.
  - Required: no write for the first packet; second packet writes Addr=21, Data=AABBCCDD.
- Reset mid-packet:
  - Stimulus: ipReset=0 for one cycle after byte 3 of a valid write packet, then a full valid packet.
  - Required: all outputs 0 and no write after reset; the following packet completes normally.
- SoP restart:
  - Stimulus: Dest=01 bytes 30,11 then a new SoP packet 31,01,02,03,04.
  - Required: single write, Addr=31, Data=01020304.
